mul_fu_ctrl: RTL and testbench

- Sequencing controller between the multiply reservation station and a shared multi-cycle multiplier datapath.
- Accepts one issued multiply at a time and drives the multiplier's start/done handshake.
- Registers the 64-bit product, selects the upper or lower word, and holds the result on a CDB request until the CDB arbiter grants it.
- Drives the `running` back-pressure signal seen by the reservation station, and squashes in-flight work on a branch-tag flush.

---
 rtl/mul_fu_ctrl_if.sv | 41 ++++
 rtl/mul_fu_ctrl.sv | 65 ++++++
 tb/tb_mul_fu_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_fu_ctrl_if.sv
// mul_fu_ctrl_if: branch tag type plus the RS/multiplier/CDB bundle; master = controller side, slave = environment side
package mul_fu_pkg;
  typedef struct packed {
    logic       sign;
    logic [3:0] tag;
  } branch_tag_t;
endpackage

interface mul_fu_if import mul_fu_pkg::*; #(parameter int ROB_WIDTH = 3);
  logic                 flush;
  branch_tag_t          flush_tag;
  logic                 issue;
  logic [31:0]          operand1;
  logic [31:0]          operand2;
  branch_tag_t          br_tag_in;
  logic [ROB_WIDTH-1:0] dest_ROB_in;
  logic [1:0]           mul_type;
  logic                 upper;
  logic                 running;
  logic                 mul_start;
  logic [31:0]          mul_a;
  logic [31:0]          mul_b;
  logic                 mul_a_signed;
  logic                 mul_b_signed;
  logic                 mul_done;
  logic [63:0]          mul_product;
  logic                 cdb_req;
  logic [31:0]          cdb_rd_v;
  logic [ROB_WIDTH-1:0] cdb_dest_ROB;
  logic                 cdb_grant;
  modport master (
    input  flush, flush_tag, issue, operand1, operand2, br_tag_in, dest_ROB_in, mul_type, upper,
           mul_done, mul_product, cdb_grant,
    output running, mul_start, mul_a, mul_b, mul_a_signed, mul_b_signed, cdb_req, cdb_rd_v, cdb_dest_ROB
  );
  modport slave (
    output flush, flush_tag, issue, operand1, operand2, br_tag_in, dest_ROB_in, mul_type, upper,
           mul_done, mul_product, cdb_grant,
    input  running, mul_start, mul_a, mul_b, mul_a_signed, mul_b_signed, cdb_req, cdb_rd_v, cdb_dest_ROB
  );
endinterface

// File: rtl/mul_fu_ctrl.sv
// mul_fu_ctrl: multiply FU sequencer; ports clk, rst, fu (mul_fu_if.master: RS issue/running, multiplier start/done, CDB req/grant, flush)
module mul_fu_ctrl import mul_fu_pkg::*; #(
  parameter int ROB_WIDTH = 3
) (
  input logic      clk,
  input logic      rst,
  mul_fu_if.master fu
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, WAIT = 3'd2, RESULT = 3'd3, DRAIN = 3'd4;
  logic [2:0]           state_q, state_d;
  logic [31:0]          a_q, b_q, rd_q;
  logic                 as_q, bs_q, upper_q;
  branch_tag_t          tag_q;
  logic [ROB_WIDTH-1:0] rob_q;
  logic                 kill_in, kill_held, capture, take, busy;
  function automatic logic killed(branch_tag_t t, branch_tag_t f);
    return t.sign == f.sign ? (t.tag & f.tag) == f.tag : (t.tag & f.tag) == t.tag;
  endfunction
  always_comb begin
    kill_in   = fu.flush && killed(fu.br_tag_in, fu.flush_tag);
    kill_held = fu.flush && killed(tag_q, fu.flush_tag);
    capture   = fu.issue && !kill_in && (state_q == IDLE || (state_q == RESULT && fu.cdb_grant));
    busy      = state_q == START || state_q == WAIT;
    take      = busy && fu.mul_done && !kill_held;
    state_d   = state_q == IDLE   ? (capture ? START : IDLE) :
                busy              ? (fu.mul_done ? (kill_held ? IDLE : RESULT) : (kill_held ? DRAIN : WAIT)) :
                state_q == DRAIN  ? (fu.mul_done ? IDLE : DRAIN) :
                state_q == RESULT ? (fu.cdb_grant ? (capture ? START : IDLE) : (kill_held ? IDLE : RESULT)) :
                IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      upper_q <= 1'b0;
      tag_q   <= '0;
      rob_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        a_q     <= fu.operand1;
        b_q     <= fu.operand2;
        as_q    <= fu.mul_type == 2'd1 || fu.mul_type == 2'd2;
        bs_q    <= fu.mul_type == 2'd1;
        upper_q <= fu.upper;
        tag_q   <= fu.br_tag_in;
        rob_q   <= fu.dest_ROB_in;
      end
      if (take) rd_q <= upper_q ? fu.mul_product[63:32] : fu.mul_product[31:0];
    end
  end
  assign fu.running      = busy || state_q == DRAIN || (state_q == RESULT && !fu.cdb_grant);
  assign fu.mul_start    = state_q == START;
  assign fu.mul_a        = a_q;
  assign fu.mul_b        = b_q;
  assign fu.mul_a_signed = as_q;
  assign fu.mul_b_signed = bs_q;
  assign fu.cdb_req      = state_q == RESULT;
  assign fu.cdb_rd_v     = rd_q;
  assign fu.cdb_dest_ROB = rob_q;
endmodule

// File: tb/tb_mul_fu_ctrl.sv
// tb_mul_fu_ctrl: scoreboard bench with a variable-latency multiplier model and directed ops
module tb_mul_fu_ctrl;
  import mul_fu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int mdly = 4;
  logic [34:0] exp_q[$];
  mul_fu_if #(.ROB_WIDTH(3)) fu();
  mul_fu_ctrl #(.ROB_WIDTH(3)) dut (.clk(clk), .rst(rst), .fu(fu));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                          input logic up, input branch_tag_t tg, input logic [2:0] d);
    fu.operand1 = a;
    fu.operand2 = b;
    fu.mul_type = t;
    fu.upper = up;
    fu.br_tag_in = tg;
    fu.dest_ROB_in = d;
    fu.issue = 1'b1;
    tick;
    fu.issue = 1'b0;
  endtask
  task automatic wait_req(input string n);
    for (int i = 0; i < 20 && fu.cdb_req !== 1'b1; i++) tick;
    chk(n, 64'(fu.cdb_req), 64'd1);
  endtask
  initial begin
    logic [63:0] ea, eb;
    fu.mul_done = 1'b0;
    fu.mul_product = '0;
    forever begin
      @(negedge clk);
      if (!rst && fu.mul_start) begin
        ea = fu.mul_a_signed ? {{32{fu.mul_a[31]}}, fu.mul_a} : {32'd0, fu.mul_a};
        eb = fu.mul_b_signed ? {{32{fu.mul_b[31]}}, fu.mul_b} : {32'd0, fu.mul_b};
        repeat (mdly - 1) @(negedge clk);
        fu.mul_product = ea * eb;
        fu.mul_done = 1'b1;
        @(negedge clk);
        fu.mul_done = 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst && fu.issue && fu.running) begin
      errors++;
      $display("FAIL issue_while_running: got issue=1 running=1 expected no issue");
    end
    if (!rst && fu.cdb_req && fu.cdb_grant) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_broadcast: got data %0h dest %0d expected none", fu.cdb_rd_v, fu.cdb_dest_ROB);
      end else begin
        e = exp_q.pop_front();
        chk("cdb_data", 64'(fu.cdb_rd_v), 64'(e[34:3]));
        chk("cdb_dest", 64'(fu.cdb_dest_ROB), 64'(e[2:0]));
      end
    end
  end
  initial begin
    int seen;
    fu.flush = 1'b0;
    fu.flush_tag = '0;
    fu.issue = 1'b0;
    fu.operand1 = '0;
    fu.operand2 = '0;
    fu.br_tag_in = '0;
    fu.dest_ROB_in = '0;
    fu.mul_type = '0;
    fu.upper = 1'b0;
    fu.cdb_grant = 1'b0;
    tick;
    tick;
    chk("rst_outs", {fu.running, fu.mul_start, fu.cdb_req, fu.mul_a_signed, fu.mul_b_signed}, 64'd0);
    chk("rst_data", {fu.mul_a, fu.mul_b}, 64'd0);
    chk("rst_cdb", {fu.cdb_rd_v, 29'd0, fu.cdb_dest_ROB}, 64'd0);
    rst = 1'b0;
    tick;
    mdly = 4;
    exp_q.push_back({32'hFFFF_FFFA, 3'd5});
    issue_op(32'hFFFF_FFFE, 32'd3, 2'd1, 1'b0, 5'b00001, 3'd5);
    chk("t1_start", 64'(fu.mul_start), 64'd1);
    chk("t1_signs", {fu.mul_a_signed, fu.mul_b_signed}, 64'd3);
    chk("t1_mul_a", 64'(fu.mul_a), 64'hFFFF_FFFE);
    tick;
    chk("t1_start_pulse", 64'(fu.mul_start), 64'd0);
    wait_req("t1_req");
    chk("t1_running_req", 64'(fu.running), 64'd1);
    chk("t1_rd", 64'(fu.cdb_rd_v), 64'hFFFF_FFFA);
    fu.cdb_grant = 1'b1;
    #1;
    chk("t1_running_grant", 64'(fu.running), 64'd0);
    tick;
    fu.cdb_grant = 1'b0;
    chk("t1_idle", {fu.cdb_req, fu.running}, 64'd0);
    mdly = 1;
    exp_q.push_back({32'hFFFF_FFFE, 3'd2});
    issue_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b1, 5'b00001, 3'd2);
    chk("t2_start", 64'(fu.mul_start), 64'd1);
    chk("t2_signs", {fu.mul_a_signed, fu.mul_b_signed}, 64'd0);
    tick;
    chk("t2_min_latency_req", 64'(fu.cdb_req), 64'd1);
    fu.cdb_grant = 1'b1;
    tick;
    fu.cdb_grant = 1'b0;
    mdly = 2;
    exp_q.push_back({32'h0000_002A, 3'd3});
    issue_op(32'd7, 32'd6, 2'd0, 1'b0, 5'b00001, 3'd3);
    wait_req("t3_req");
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_hold", {fu.cdb_req, fu.cdb_rd_v, 29'd0, fu.cdb_dest_ROB}, {1'b1, 32'h2A, 29'd0, 3'd3});
    end
    fu.cdb_grant = 1'b1;
    #1;
    chk("t3_running_grant", 64'(fu.running), 64'd0);
    exp_q.push_back({32'hFFFF_FFFF, 3'd4});
    issue_op(32'h8000_0000, 32'd2, 2'd2, 1'b1, 5'b00001, 3'd4);
    fu.cdb_grant = 1'b0;
    chk("t3_b2b_start", 64'(fu.mul_start), 64'd1);
    chk("t3_signs", {fu.mul_a_signed, fu.mul_b_signed}, 64'd2);
    tick;
    chk("t3_start_once", 64'(fu.mul_start), 64'd0);
    wait_req("t3_req2");
    fu.cdb_grant = 1'b1;
    tick;
    fu.cdb_grant = 1'b0;
    mdly = 6;
    issue_op(32'd3, 32'd5, 2'd0, 1'b0, 5'b00110, 3'd6);
    tick;
    fu.flush = 1'b1;
    fu.flush_tag = 5'b00010;
    tick;
    fu.flush = 1'b0;
    chk("t4_drain", {fu.running, fu.cdb_req}, 64'd2);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (fu.cdb_req) seen++;
    end
    chk("t4_no_req", 64'(seen), 64'd0);
    chk("t4_idle", 64'(fu.running), 64'd0);
    exp_q.push_back({32'd15, 3'd6});
    issue_op(32'd3, 32'd5, 2'd0, 1'b0, 5'b00110, 3'd6);
    tick;
    fu.flush = 1'b1;
    fu.flush_tag = 5'b01000;
    tick;
    fu.flush = 1'b0;
    chk("t4b_wait", 64'(fu.running), 64'd1);
    wait_req("t4b_req");
    fu.cdb_grant = 1'b1;
    tick;
    fu.cdb_grant = 1'b0;
    mdly = 2;
    fu.flush = 1'b1;
    fu.flush_tag = 5'b10111;
    issue_op(32'd4, 32'd4, 2'd0, 1'b0, 5'b00110, 3'd1);
    fu.flush = 1'b0;
    chk("t5_killed_issue", {fu.mul_start, fu.running}, 64'd0);
    issue_op(32'd2, 32'd2, 2'd0, 1'b0, 5'b10001, 3'd7);
    wait_req("t5_req");
    fu.flush = 1'b1;
    fu.flush_tag = 5'b10001;
    tick;
    fu.flush = 1'b0;
    chk("t5_kill_result", {fu.cdb_req, fu.running}, 64'd0);
    mdly = 5;
    issue_op(32'd9, 32'd9, 2'd1, 1'b0, 5'b00001, 3'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_rst_outs", {fu.running, fu.mul_start, fu.cdb_req, fu.mul_a_signed, fu.mul_b_signed}, 64'd0);
    chk("t6_rst_data", {fu.mul_a, fu.cdb_rd_v}, 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (fu.cdb_req || fu.running) seen++;
    end
    chk("t6_done_ignored", 64'(seen), 64'd0);
    tick;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
